// File: rtl/fp_mac_pkg.sv
// Shared widths and types for the floating-point MAC pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_mac_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SUM_W    = 28;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Normalized mantissa keeps hidden bit, fraction and G/R/S; the exponent
    // carries a sign bit because left shifts can drive it below zero.
    localparam int NORM_W   = SUM_W - 1;
    localparam int S1_EXP_W = EXP_W + 2;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [FRAC_W-1:0] fraction;
    } fp32_t;

    typedef struct packed {
        logic                valid;
        logic                sign;
        logic [S1_EXP_W-1:0] exponent;
        logic [NORM_W-1:0]   mantissa;
    } norm_stage_t;

    function automatic fp32_t fp_signed_zero(input logic sign);
        fp32_t r;
        r.sign     = sign;
        r.exponent = '0;
        r.fraction = '0;
        return r;
    endfunction

    function automatic fp32_t fp_signed_inf(input logic sign);
        fp32_t r;
        r.sign     = sign;
        r.exponent = EXP_W'(EXP_MAX);
        r.fraction = '0;
        return r;
    endfunction

endpackage

// File: rtl/lzc27.sv
// Leading-zero counter over a 27-bit word; returns 27 for an all-zero input.
// Latency: combinational.
// Backpressure: n/a.
module lzc27 (
    input  logic [26:0] data,
    output logic [4:0]  count
);

    // Scan upward so the most significant set bit has the final say.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (data[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/step6_normalize_round.sv
// Normalize, round and pack the step-5 sum into IEEE-754 single precision.
// Latency: 2 cycles; STEP6_ROUND_NEAREST_EVEN_EN selects round-nearest-even, else truncation.
// Backpressure: whole pipe stalls while out_valid && !out_ready; in_ready drops with it.
module step6_normalize_round
    import fp_mac_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W:0]   in_exponent,
    input  logic [SUM_W-1:0] in_mantissa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_underflow
);

`ifdef STEP6_ROUND_NEAREST_EVEN_EN
    localparam bit ROUND_RNE = 1'b1;
`else
    localparam bit ROUND_RNE = 1'b0;
`endif

    localparam logic signed [S1_EXP_W:0] EXP_OVF = (S1_EXP_W + 1)'(EXP_MAX);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: normalize ----------------
    logic [4:0]  lz;
    norm_stage_t s1_d;
    norm_stage_t s1_q;

    lzc27 u_lzc (
        .data  (in_mantissa[NORM_W-1:0]),
        .count (lz)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sign  = in_sign;
        if (in_mantissa == '0) begin
            s1_d.exponent = '0;
            s1_d.mantissa = '0;
        end else if (in_mantissa[SUM_W-1]) begin
            // Carry: the bit falling off the bottom must stay visible as sticky.
            s1_d.mantissa = {in_mantissa[SUM_W-1:2], in_mantissa[1] | in_mantissa[0]};
            s1_d.exponent = {1'b0, in_exponent} + S1_EXP_W'(1);
        end else begin
            s1_d.mantissa = in_mantissa[NORM_W-1:0] << lz;
            s1_d.exponent = {1'b0, in_exponent} - {{(S1_EXP_W-5){1'b0}}, lz};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '0;
        end else if (en) begin
            s1_q <= s1_d;
        end
    end

    // ---------------- stage 2: round, classify, pack ----------------
    logic                       guard;
    logic                       sticky;
    logic                       lsb;
    logic                       round_inc;
    logic                       frac_carry;
    logic [FRAC_W-1:0]          frac_rnd;
    logic signed [S1_EXP_W:0]   exp_rnd;
    logic                       is_zero;
    logic                       is_unf;
    logic                       is_ovf;
    fp32_t                      res_d;

    always_comb begin
        guard     = s1_q.mantissa[2];
        sticky    = s1_q.mantissa[1] | s1_q.mantissa[0];
        lsb       = s1_q.mantissa[3];
        round_inc = ROUND_RNE && guard && (sticky || lsb);

        // A carry out of the fraction means the significand rounded up to 2.0.
        {frac_carry, frac_rnd} = {1'b0, s1_q.mantissa[NORM_W-2:3]} + (FRAC_W + 1)'(round_inc);
        exp_rnd = {s1_q.exponent[S1_EXP_W-1], s1_q.exponent}
                + {{S1_EXP_W{1'b0}}, frac_carry};

        // Every nonzero sum leaves stage 1 with its hidden bit set.
        is_zero = !s1_q.mantissa[NORM_W-1];
        is_unf  = !is_zero && (exp_rnd <= 0);
        is_ovf  = !is_zero && !is_unf && (exp_rnd >= EXP_OVF);

        if (is_zero || is_unf) begin
            res_d = fp_signed_zero(s1_q.sign);
        end else if (is_ovf) begin
            res_d = fp_signed_inf(s1_q.sign);
        end else begin
            res_d.sign     = s1_q.sign;
            res_d.exponent = exp_rnd[EXP_W-1:0];
            res_d.fraction = frac_rnd;
        end
    end

    fp32_t res_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            res_q         <= '0;
            out_zero      <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (en) begin
            out_valid     <= s1_q.valid;
            res_q         <= s1_q.valid ? res_d : '0;
            out_zero      <= s1_q.valid && is_zero;
            out_overflow  <= s1_q.valid && is_ovf;
            out_underflow <= s1_q.valid && is_unf;
        end
    end

    assign out_result = res_q;

endmodule

// File: tb/tb_step6_normalize_round.sv
// Directed bench for step6_normalize_round with a queue scoreboard of expected results.
module tb_step6_normalize_round;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exponent;
    logic [27:0] in_mantissa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

`ifdef STEP6_ROUND_NEAREST_EVEN_EN
    localparam logic [31:0] RND_LSB_UP   = 32'h3F800002;
    localparam logic [31:0] RND_CARRY    = 32'h40000000;
    localparam logic [31:0] RND_STICKY   = 32'h40000001;
`else
    localparam logic [31:0] RND_LSB_UP   = 32'h3F800001;
    localparam logic [31:0] RND_CARRY    = 32'h3FFFFFFF;
    localparam logic [31:0] RND_STICKY   = 32'h40000000;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    exp_t  pend;
    string pend_tag;
    bit    accepted;
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    pops      = 0;

    step6_normalize_round dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exponent   (in_exponent),
        .in_mantissa   (in_mantissa),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    endtask

    // Sample at the falling edge: pop on output handshake, push on input handshake.
    task automatic tick();
        exp_t  e;
        string t;
        @(negedge clock);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {32'd0, out_result}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                t = sb_tag.pop_front();
                pops++;
                check(t, {out_result, out_zero, out_overflow, out_underflow},
                         {e.result, e.zero, e.ovf, e.unf});
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            sb.push_back(pend);
            sb_tag.push_back(pend_tag);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic s, input logic [8:0] e, input logic [27:0] m,
                        input logic [31:0] r, input logic z, input logic o, input logic u,
                        input string tag);
        in_valid    = 1'b1;
        in_sign     = s;
        in_exponent = e;
        in_mantissa = m;
        pend        = '{r, z, o, u};
        pend_tag    = tag;
        accepted    = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) tick();
        if (!accepted) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int pops0;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = '0;
        in_mantissa = '0;
        out_ready   = 1'b1;
        #2;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_outputs", {out_result, out_zero, out_overflow, out_underflow}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        #10 resetn = 1'b1;
        @(posedge clock);
        #1;

        // Directed vectors streamed back to back.
        send(0, 9'd127, 28'h4000000, 32'h3F800000, 0, 0, 0, "basic_one");
        send(0, 9'd127, 28'h8000000, 32'h40000000, 0, 0, 0, "carry_shift");
        send(0, 9'd254, 28'h8000000, 32'h7F800000, 0, 1, 0, "carry_overflow");
        send(0, 9'd127, 28'h400000C, RND_LSB_UP,   0, 0, 0, "round_lsb_odd");
        send(0, 9'd127, 28'h4000004, 32'h3F800000, 0, 0, 0, "round_tie_even");
        send(1, 9'd50,  28'h0000000, 32'h80000000, 1, 0, 0, "zero_neg");
        send(0, 9'd10,  28'h0000008, 32'h00000000, 0, 0, 1, "underflow_lz");
        send(0, 9'd127, 28'h7FFFFFC, RND_CARRY,    0, 0, 0, "round_carry_out");
        send(0, 9'd127, 28'h8000009, RND_STICKY,   0, 0, 0, "carry_sticky");
        send(0, 9'd127, 28'h2000000, 32'h3F000000, 0, 0, 0, "shift_left_1");
        send(0, 9'd1,   28'h4000000, 32'h00800000, 0, 0, 0, "exp_min_normal");
        send(1, 9'd0,   28'h4000000, 32'h80000000, 0, 0, 1, "exp_zero_unf");
        send(0, 9'd5,   28'h0200000, 32'h00000000, 0, 0, 1, "lz_to_exp0");
        send(0, 9'd6,   28'h0200000, 32'h00800000, 0, 0, 0, "lz_to_exp1");
        send(1, 9'd255, 28'h4000000, 32'hFF800000, 0, 1, 0, "exp255_ovf");
        idle();
        drain();

        // Backpressure: stall 3 cycles once the first result is on the output.
        pops0 = pops;
        send(0, 9'd127, 28'h4000000, 32'h3F800000, 0, 0, 0, "bp_0");
        send(0, 9'd128, 28'h4000000, 32'h40000000, 0, 0, 0, "bp_1");
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        in_exponent = 9'd129;
        pend        = '{32'h40800000, 1'b0, 1'b0, 1'b0};
        pend_tag    = "bp_2";
        out_ready   = 1'b0;
        #1;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_result", {32'd0, out_result}, 64'h3F800000);
            check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        send(0, 9'd129, 28'h4000000, 32'h40800000, 0, 0, 0, "bp_2");
        send(0, 9'd130, 28'h4000000, 32'h41000000, 0, 0, 0, "bp_3");
        idle();
        drain();
        check("bp_result_count", 64'(pops - pops0), 64'd4);

        // Reset with both stages full, then measure latency of the next input.
        send(0, 9'd127, 28'h4000000, 32'h3F800000, 0, 0, 0, "rst_a");
        send(0, 9'd128, 28'h4000000, 32'h40000000, 0, 0, 0, "rst_b");
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_outputs", {out_result, out_zero, out_overflow, out_underflow}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        sb_tag.delete();
        idle();
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;
        send(1, 9'd130, 28'h4000000, 32'hC1000000, 0, 0, 0, "post_reset");
        check("lat_after_1_edge", {63'd0, out_valid}, 64'd0);
        idle();
        tick();
        check("lat_after_2_edges", {63'd0, out_valid}, 64'd1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
